// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory execution unit: micro-op layout, access
// size/type encodings, LSU state encoding and small address helpers.
package mem_access_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_LD   = 2'd1,
    MEM_ST   = 2'd2
  } mem_type_t;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic            valid;
    mem_type_t       mem_type;
    mem_size_t       mem_size;
    logic            mem_signed;
    logic [4:0]      rd;
    logic [5:0]      rob_tag;
    logic [XLEN-1:0] imm;
  } micro_op_t;

  // Byte enables for an access of the given size at byte offset off.
  // Unknown size encodings are treated as a full word.
  function automatic logic [3:0] byte_mask(mem_size_t size, logic [1:0] off);
    case (size)
      MEM_B:   return 4'b0001 << off;
      MEM_H:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Clear the low address bits down to the natural alignment of the access.
  function automatic logic [XLEN-1:0] natural_align(logic [XLEN-1:0] ea, mem_size_t size);
    case (size)
      MEM_B:   return ea;
      MEM_H:   return {ea[XLEN-1:1], 1'b0};
      default: return {ea[XLEN-1:2], 2'b00};
    endcase
  endfunction

  // True when the access does not sit on its natural boundary.
  function automatic logic is_misaligned(logic [XLEN-1:0] ea, mem_size_t size);
    case (size)
      MEM_B:   return 1'b0;
      MEM_H:   return ea[0];
      default: return |ea[1:0];
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the memory execution unit
// (master) and the data memory (slave).
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_wdata;
  logic [3:0]      mem_req_mask;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_mask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_mask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load-data alignment: moves the addressed byte lane down to bit 0 and
// sign- or zero-extends it to XLEN according to the access size.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  mem_size_t       size,
  input  logic            mem_signed,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0]   shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Shift the full word so the addressed byte lands in the low lane, then extend.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    data    = shifted;
    case (size)
      MEM_B: data = mem_signed ? {{(XLEN-8){byte_s[7]}}, byte_s}
                               : {{(XLEN-8){1'b0}}, shifted[7:0]};
      MEM_H: data = mem_signed ? {{(XLEN-16){half_s[15]}}, half_s}
                               : {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory execution unit: accepts one load/store micro-op while idle, forms
// the effective address, runs one request/response exchange with the data
// memory and emits a single-cycle write-back record.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (misaligned accesses raise
// an exception instead of being silently aligned).
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  micro_op_t           uop_in,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  output logic                ex_busy,
  mem_access_unit_if.master   mem,
  output logic                wb_valid,
  output micro_op_t           wb_uop,
  output logic [XLEN-1:0]     wb_data,
  output logic                wb_exception
);

  lsu_state_t      state_q, state_d;
  logic            accept;
  logic            misalign;
  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] ea_nat;
  logic [XLEN-1:0] load_data;

  logic [XLEN-1:0] req_addr_q;
  logic            req_we_q;
  logic [XLEN-1:0] req_wdata_q;
  logic [3:0]      req_mask_q;
  logic [1:0]      off_q;
  micro_op_t       wb_uop_q;
  logic [XLEN-1:0] wb_data_q;

  // Effective address wraps modulo 2^XLEN; the immediate is already sign-extended.
  assign ea     = rs1_data + uop_in.imm;
  assign ea_nat = natural_align(ea, uop_in.mem_size);
  assign accept = (state_q == LSU_IDLE) && uop_in.valid &&
                  ((uop_in.mem_type == MEM_LD) || (uop_in.mem_type == MEM_ST));

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(ea, uop_in.mem_size);
`else
  assign misalign = 1'b0;
`endif

  // State register; reset abandons any outstanding memory exchange.
  always_ff @(posedge clock) begin
    if (reset) state_q <= LSU_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_d           = state_q;
    ex_busy           = 1'b0;
    mem.mem_req_valid = 1'b0;
    wb_valid          = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (accept) state_d = misalign ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ: begin
        ex_busy           = 1'b1;
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) state_d = LSU_RESP;
      end
      LSU_RESP: begin
        ex_busy = 1'b1;
        if (mem.mem_resp_valid) state_d = LSU_DONE;
      end
      LSU_DONE: begin
        ex_busy  = 1'b1;
        wb_valid = 1'b1;
        state_d  = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  mem_load_align u_load_align (
    .rdata      (mem.mem_resp_rdata),
    .offset     (off_q),
    .size       (wb_uop_q.mem_size),
    .mem_signed (wb_uop_q.mem_signed),
    .data       (load_data)
  );

  // Latch request fields at accept and capture load data on the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      req_mask_q  <= '0;
      off_q       <= '0;
      wb_uop_q    <= '0;
      wb_data_q   <= '0;
    end else if (accept) begin
      req_addr_q  <= {ea_nat[XLEN-1:2], 2'b00};
      req_we_q    <= (uop_in.mem_type == MEM_ST);
      req_wdata_q <= rs2_data << {ea_nat[1:0], 3'b000};
      req_mask_q  <= byte_mask(uop_in.mem_size, ea_nat[1:0]);
      off_q       <= ea_nat[1:0];
      wb_uop_q    <= uop_in;
      wb_data_q   <= misalign ? ea : '0;
    end else if ((state_q == LSU_RESP) && mem.mem_resp_valid && !req_we_q) begin
      wb_data_q   <= load_data;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic exc_q;

  // Remember whether the accepted access was rejected for misalignment.
  always_ff @(posedge clock) begin
    if (reset)       exc_q <= 1'b0;
    else if (accept) exc_q <= misalign;
  end

  assign wb_exception = (state_q == LSU_DONE) && exc_q;
`else
  assign wb_exception = 1'b0;
`endif

  assign mem.mem_req_addr  = req_addr_q;
  assign mem.mem_req_we    = req_we_q;
  assign mem.mem_req_wdata = req_wdata_q;
  assign mem.mem_req_mask  = req_mask_q;
  assign wb_uop            = wb_uop_q;
  assign wb_data           = wb_data_q;

  // The issue queue must hold off new uops while this unit is busy.
  a_no_issue_when_busy: assert property (@(posedge clock) disable iff (reset)
    !(ex_busy && uop_in.valid));

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory execution unit at the output side of the memory issue queue. Accepts one issued memory micro-op per transaction, with operands read from the integer PRF, and forms the effective address. Runs a valid/ready request and valid response transaction with the data memory, and returns a write-back record. Drives `ex_busy` back to the issue queue so the queue presents a new uop only when this unit is idle.

## Interface
- `XLEN`, 32, data and address width.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `uop_in`  in  micro_op_t  issued uop; consumed only in IDLE when `uop_in.valid`.
- `rs1_data`  in  XLEN  base operand, valid in the same cycle as `uop_in`.
- `rs2_data`  in  XLEN  store data, valid in the same cycle as `uop_in`.
- `ex_busy`  out  1  high whenever the state is not IDLE.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  XLEN  word-aligned address; `addr[1:0]` is always 0.
- `mem_req_we`  out  1  1 = store.
- `mem_req_wdata`  out  XLEN  store data shifted to its byte lane.
- `mem_req_mask`  out  4  byte enables.
- `mem_resp_valid`  in  1  response or store acknowledge.
- `mem_resp_rdata`  in  XLEN  load data, full word.
- `wb_valid`  out  1  one-cycle write-back pulse.
- `wb_uop`  out  micro_op_t  copy of the accepted uop; carries `rd` and the ROB tag.
- `wb_data`  out  XLEN  extended load data; 0 for stores; faulting address on exception.
- `wb_exception`  out  1  misaligned access, valid with `wb_valid`.

## Operation
- States: IDLE, REQ, RESP, DONE.
- **IDLE:** if `uop_in.valid` and `mem_type` is MEM_LD or MEM_ST, perform the accept:
  - latch the uop;
  - latch `ea = rs1_data + imm`, truncated to XLEN;
  - latch the shifted store data and mask;
  - go to REQ.
- **IDLE, other inputs:** MEM_NONE uops and invalid uops are ignored.
- **REQ:** `mem_req_valid = 1`; address, we, wdata and mask stay stable until `mem_req_ready`. On ready, go to RESP.
- **RESP:** wait for `mem_resp_valid`. On a load, register the extended data. Go to DONE.
- **DONE:** `wb_valid = 1` for exactly one cycle, then IDLE.
- Byte mask by size:
  - byte: `4'b0001 << ea[1:0]`;
  - half: `4'b0011 << ea[1:0]`;
  - word: `4'b1111`.
- Store data: `rs2_data << (8*ea[1:0])`; lanes outside the mask are don't-care.
- Load data: `mem_resp_rdata >> (8*ea[1:0])`, then sign- or zero-extend from 8/16/32 bits per `mem_signed`.
- `mem_resp_valid` outside RESP is ignored.
- A uop presented while `ex_busy = 1` is dropped. Flag this with a simulation assertion; it is an issue-queue protocol violation.
- `reset` in any state: return to IDLE; drop any outstanding request and response. Do not pulse `wb_valid`.

## Timing
- Reset values:
  - state IDLE;
  - `ex_busy`, `mem_req_valid`, `wb_valid`, `wb_exception` all 0;
  - `wb_uop`, `wb_data`, `mem_req_*` all 0.
- Accept in cycle 0. `mem_req_valid` rises in cycle 1.
- Minimum latency, with ready and response each in their first cycle: `wb_valid` in cycle 3. Next accept is possible in cycle 4.
- Each cycle of `mem_req_ready = 0` stall adds one cycle; the same holds for each cycle of missing `mem_resp_valid`.
- `ex_busy` is high in cycles 1 through DONE inclusive. It is combinational from the state register only.
- `mem_req_valid` must not drop while in REQ.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - misaligned accesses are half with `ea[0]=1`, or word with `ea[1:0]≠0`;
  - they bypass REQ/RESP and go IDLE→DONE;
  - `wb_exception = 1`, `wb_data = ea`;
  - no memory request is made.
- Not defined:
  - no check; `ea` low bits are cleared to natural alignment before lane and mask computation;
  - `wb_exception` is tied 0.

## Structure
- Shared package `src/common/micro_op.svh`:
  - `mem_size_t` (MEM_B, MEM_H, MEM_W);
  - uop fields `mem_size` and `mem_signed`;
  - `lsu_state_t` enum.
- Sub-module `mem_load_align`: combinational shift and extend; inputs rdata, offset, size, signed.

## Test plan
- LW at `rs1=0x1000`, `imm=4`, ready and response immediate → req addr 0x1004, mask 1111; `wb_valid` in cycle 3 with `rdata`; `ex_busy` high in cycles 1–3.
- LB, signed, at ea 0x2003, rdata 0x80FFFFFF → mask 1000, `wb_data` 0xFFFFFF80.
- LHU at ea 0x2002, rdata 0xBEEF1234 → `wb_data` 0x0000BEEF.
- SH at ea 0x3002, `rs2=0x0000ABCD`, ready held low for 3 cycles → wdata 0xABCD0000, mask 1100; request held stable; `wb_valid` 3 cycles later than the minimum.
- SW at ea 0x4001:
  - with macro: no `mem_req_valid`; `wb_exception=1`, `wb_data` 0x4001 in cycle 1;
  - without macro: req addr 0x4000, mask 1111.
- `reset` asserted during RESP → next cycle IDLE, `ex_busy=0`, no `wb_valid`; a late `mem_resp_valid` is ignored.
